// File: rtl/atconv_pkg.sv
// Shared types for the atrous-convolution engine: FSM states, 3x3 tap weight
// table (shift + sign) and the default bias.
package atconv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L0_RD,
        S_L0_ACC,
        S_L0_WR,
        S_L1_RD,
        S_L1_ACC,
        S_L1_WR,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       neg;
        logic [2:0] shift;
    } tap_weight_t;

    // Extra accumulator fraction bits beyond the pixel's own FRAC bits.
    localparam int XFRAC        = 4;
    localparam int BIAS_DEFAULT = -12;

    // Weights in 1/16 units: centre +16, left/right -4, up/down -2, corners -1.
    function automatic tap_weight_t tap_weight(input logic [3:0] k);
        case (k)
            4'd1, 4'd7: tap_weight = '{neg: 1'b1, shift: 3'd1};
            4'd3, 4'd5: tap_weight = '{neg: 1'b1, shift: 3'd2};
            4'd4:       tap_weight = '{neg: 1'b0, shift: 3'd4};
            default:    tap_weight = '{neg: 1'b1, shift: 3'd0};
        endcase
    endfunction

endpackage

// File: rtl/atconv_tap_addr.sv
// Combinational tap address generator: applies the dilated 3x3 offset for a
// tap index and clamps each coordinate to the image (replicate padding).
module atconv_tap_addr
    import atconv_pkg::*;
#(
    parameter int IMG_LOG2 = 6,
    parameter int DILATION = 2
) (
    input  logic [IMG_LOG2-1:0]   row,
    input  logic [IMG_LOG2-1:0]   col,
    input  logic [3:0]            tap,
    output logic [2*IMG_LOG2-1:0] addr
);

    localparam int CW = IMG_LOG2 + 2;
    localparam logic signed [CW-1:0] DIL  = CW'(DILATION);
    localparam logic signed [CW-1:0] MAXC = CW'((1 << IMG_LOG2) - 1);

    // Offset selectors: 0 = -D, 1 = 0, 2 = +D
    logic [1:0] rsel;
    logic [1:0] csel_t;

    function automatic logic [IMG_LOG2-1:0] clamp_coord(input logic [IMG_LOG2-1:0] base,
                                                        input logic [1:0] sel);
        logic signed [CW-1:0] v;
        v = $signed({2'b00, base});
        if (sel == 2'd0)
            v = v - DIL;
        else if (sel == 2'd2)
            v = v + DIL;
        if (v < 0)
            clamp_coord = '0;
        else if (v > MAXC)
            clamp_coord = '1;
        else
            clamp_coord = IMG_LOG2'(v);
    endfunction

    always_comb begin
        case (tap)
            4'd0, 4'd1, 4'd2: rsel = 2'd0;
            4'd3, 4'd4, 4'd5: rsel = 2'd1;
            default:          rsel = 2'd2;
        endcase
        case (tap)
            4'd0, 4'd3, 4'd6: csel_t = 2'd0;
            4'd1, 4'd4, 4'd7: csel_t = 2'd1;
            default:          csel_t = 2'd2;
        endcase
    end

    assign addr = {clamp_coord(row, rsel), clamp_coord(col, csel_t)};

endmodule

// File: rtl/atconv_param_engine.sv
// Atrous 3x3 convolution (bias + ReLU) into layer-0 memory, then 2x2 max/avg
// pooling with ceil rounding into layer-1 memory.
module atconv_param_engine
    import atconv_pkg::*;
#(
    parameter int IMG_LOG2 = 6,
    parameter int DW       = 13,
    parameter int FRAC     = 4,
    parameter int DILATION = 2,
    parameter int BIAS     = BIAS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  pool_avg,
    output logic                  busy,
    output logic [2*IMG_LOG2-1:0] iaddr,
    input  logic [DW-1:0]         idata,
    output logic                  crd,
    output logic [2*IMG_LOG2-1:0] caddr_rd,
    input  logic [DW-1:0]         cdata_rd,
    output logic                  cwr,
    output logic [2*IMG_LOG2-1:0] caddr_wr,
    output logic [DW-1:0]         cdata_wr,
    output logic                  csel
);

    localparam int AW    = 2 * IMG_LOG2;
    localparam int ACC_W = DW + 6;
    localparam logic signed [ACC_W-1:0] BIAS_ACC = ACC_W'(BIAS * (1 << XFRAC));
    localparam logic signed [ACC_W-1:0] SAT_ACC  = ACC_W'((1 << DW) - 1);
    localparam logic [IMG_LOG2-1:0]     RC_ONE   = IMG_LOG2'(1);
    localparam logic [IMG_LOG2-2:0]     PC_ONE   = (IMG_LOG2 - 1)'(1);
    localparam logic [DW-FRAC-1:0]      INT_ONE  = (DW - FRAC)'(1);

    state_t                    state;
    logic [IMG_LOG2-1:0]       row, col;
    logic [IMG_LOG2-2:0]       pr, pc;
    logic [3:0]                tap;
    logic [1:0]                rd_idx;
    logic                      pool_avg_q;
    logic signed [ACC_W-1:0]   acc;
    logic [DW-1:0]             pmax;
    logic [DW+1:0]             psum;
    logic [AW-1:0]             tap_addr;

    tap_weight_t               w;
    logic signed [ACC_W-1:0]   term, acc_sum, acc_fin, acc_shr;
    logic [DW-1:0]             l0_val, max_n, pool_v, pool_ceil;
    logic [DW+1:0]             sum_n;

    atconv_tap_addr #(
        .IMG_LOG2 (IMG_LOG2),
        .DILATION (DILATION)
    ) u_tap_addr (
        .row  (row),
        .col  (col),
        .tap  (tap),
        .addr (tap_addr)
    );

    // Data on idata belongs to the address issued one tap earlier.
    always_comb begin
        w       = tap_weight(tap - 4'd1);
        term    = ACC_W'(idata);
        term    = term <<< w.shift;
        if (w.neg)
            term = -term;
        acc_sum = acc + term;
        acc_fin = acc_sum + BIAS_ACC;
        acc_shr = acc_fin >>> XFRAC;
        if (acc_fin[ACC_W-1])
            l0_val = '0;
        else if (acc_shr > SAT_ACC)
            l0_val = '1;
        else
            l0_val = DW'(acc_shr);

        max_n  = (cdata_rd > pmax) ? cdata_rd : pmax;
        sum_n  = psum + (DW + 2)'(cdata_rd);
        pool_v = pool_avg_q ? DW'(sum_n >> 2) : max_n;
        if (pool_v[FRAC-1:0] == '0)
            pool_ceil = pool_v;
        else if (&pool_v[DW-1:FRAC])
            pool_ceil = {{(DW - FRAC){1'b1}}, {FRAC{1'b0}}};
        else
            pool_ceil = {pool_v[DW-1:FRAC] + INT_ONE, {FRAC{1'b0}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            iaddr      <= '0;
            crd        <= 1'b0;
            caddr_rd   <= '0;
            cwr        <= 1'b0;
            caddr_wr   <= '0;
            cdata_wr   <= '0;
            csel       <= 1'b0;
            row        <= '0;
            col        <= '0;
            pr         <= '0;
            pc         <= '0;
            tap        <= '0;
            rd_idx     <= '0;
            pool_avg_q <= 1'b0;
            acc        <= '0;
            pmax       <= '0;
            psum       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        busy       <= 1'b1;
                        pool_avg_q <= pool_avg;
                        row        <= '0;
                        col        <= '0;
                        tap        <= '0;
                        acc        <= '0;
                        state      <= S_L0_RD;
                    end
                end
                S_L0_RD: begin
                    iaddr <= tap_addr;
                    acc   <= (tap == 4'd0) ? '0 : acc_sum;
                    tap   <= tap + 4'd1;
                    if (tap == 4'd8)
                        state <= S_L0_ACC;
                end
                S_L0_ACC: begin
                    acc      <= acc_fin;
                    cwr      <= 1'b1;
                    csel     <= 1'b0;
                    caddr_wr <= {row, col};
                    cdata_wr <= l0_val;
                    state    <= S_L0_WR;
                end
                S_L0_WR: begin
                    cwr   <= 1'b0;
                    tap   <= '0;
                    col   <= col + RC_ONE;
                    state <= S_L0_RD;
                    if (col == '1) begin
                        row <= row + RC_ONE;
                        if (row == '1) begin
                            pr     <= '0;
                            pc     <= '0;
                            rd_idx <= '0;
                            state  <= S_L1_RD;
                        end
                    end
                end
                S_L1_RD: begin
                    caddr_rd <= {pr, rd_idx[1], pc, rd_idx[0]};
                    crd      <= 1'b1;
                    if (rd_idx == 2'd0) begin
                        pmax <= '0;
                        psum <= '0;
                    end else begin
                        pmax <= max_n;
                        psum <= sum_n;
                    end
                    rd_idx <= rd_idx + 2'd1;
                    if (rd_idx == 2'd3)
                        state <= S_L1_ACC;
                end
                S_L1_ACC: begin
                    crd      <= 1'b0;
                    cwr      <= 1'b1;
                    csel     <= 1'b1;
                    caddr_wr <= {2'b00, pr, pc};
                    cdata_wr <= pool_ceil;
                    state    <= S_L1_WR;
                end
                S_L1_WR: begin
                    cwr   <= 1'b0;
                    csel  <= 1'b0;
                    pc    <= pc + PC_ONE;
                    state <= S_L1_RD;
                    if (pc == '1) begin
                        pr <= pr + PC_ONE;
                        if (pr == '1)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atconv_param_engine.sv
// Directed bench for atconv_param_engine on a 16x16 image with dilation 2.
module tb_atconv_param_engine;

    localparam int LOG2    = 4;
    localparam int N       = 16;
    localparam int AW      = 8;
    localparam int DW      = 13;
    localparam int D       = 2;
    localparam int NPIX    = N * N;
    localparam int NPOOL   = NPIX / 4;
    localparam int LATENCY = 11 * NPIX + 6 * NPOOL + 2;
    localparam logic [DW-1:0] SENTINEL = 13'h1ABC;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic          pool_avg = 1'b0;
    logic          busy, crd, cwr, csel;
    logic [AW-1:0] iaddr, caddr_rd, caddr_wr;
    logic [DW-1:0] idata, cdata_rd, cdata_wr;

    logic [DW-1:0] img  [NPIX];
    logic [DW-1:0] mem0 [NPIX];
    logic [DW-1:0] mem1 [NPOOL];
    logic [DW-1:0] exp0 [NPIX];
    logic [DW-1:0] exp1 [NPOOL];
    logic          clr = 1'b0;
    logic          overlap = 1'b0;
    int            vecs = 0;
    int            miscompares = 0;
    int            edges;

    atconv_param_engine #(
        .IMG_LOG2 (LOG2),
        .DILATION (D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .pool_avg (pool_avg),
        .busy     (busy),
        .iaddr    (iaddr),
        .idata    (idata),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    assign idata    = img[iaddr];
    assign cdata_rd = mem0[caddr_rd];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NPIX; i++) mem0[i] <= SENTINEL;
            for (int i = 0; i < NPOOL; i++) mem1[i] <= SENTINEL;
            overlap <= 1'b0;
        end else begin
            if (crd && cwr) overlap <= 1'b1;
            if (cwr) begin
                if (csel) mem1[caddr_wr[AW-3:0]] <= cdata_wr;
                else      mem0[caddr_wr] <= cdata_wr;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > N - 1) return N - 1;
        return v;
    endfunction

    function automatic int wgt16(input int k);
        case (k)
            4:       return 16;
            1, 7:    return -2;
            3, 5:    return -4;
            default: return -1;
        endcase
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < NPIX; i++) exp0[i] = '0;
        for (int i = 0; i < NPOOL; i++) exp1[i] = '0;
    endtask

    task automatic fill_img(input bit rnd);
        for (int i = 0; i < NPIX; i++) img[i] = rnd ? DW'($urandom_range(0, 8191)) : '0;
    endtask

    task automatic compute_golden(input bit avg);
        int acc, v, a, b, c2, d2;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = -12 * 16;
                for (int k = 0; k < 9; k++)
                    acc += wgt16(k) * int'(img[clampi(r + (k / 3 - 1) * D) * N
                                               + clampi(c + (k % 3 - 1) * D)]);
                v = (acc < 0) ? 0 : acc / 16;
                if (v > 8191) v = 8191;
                exp0[r * N + c] = DW'(v);
            end
        end
        for (int i = 0; i < N / 2; i++) begin
            for (int j = 0; j < N / 2; j++) begin
                a  = int'(exp0[(2 * i) * N + 2 * j]);
                b  = int'(exp0[(2 * i) * N + 2 * j + 1]);
                c2 = int'(exp0[(2 * i + 1) * N + 2 * j]);
                d2 = int'(exp0[(2 * i + 1) * N + 2 * j + 1]);
                if (avg) begin
                    v = (a + b + c2 + d2) / 4;
                end else begin
                    v = a;
                    if (b > v) v = b;
                    if (c2 > v) v = c2;
                    if (d2 > v) v = d2;
                end
                if (v % 16 != 0) v = (v / 16 + 1) * 16;
                if (v > 8176) v = 8176;
                exp1[i * (N / 2) + j] = DW'(v);
            end
        end
    endtask

    // Starts a run and waits (bounded) for busy to drop; edges counts the
    // ready-sampling edge through the edge that clears busy.
    task automatic run_engine(input logic avg, input bit poke, output int n_edges);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; ready = 1'b1; pool_avg = avg;
        @(posedge clk); n_edges = 1;
        @(negedge clk); ready = 1'b0; pool_avg = ~avg;
        check("busy_after_start", busy, 1);
        while (busy === 1'b1 && n_edges < LATENCY + 50) begin
            if (poke && n_edges == 300) ready = 1'b1;
            if (poke && n_edges == 303) ready = 1'b0;
            @(posedge clk); n_edges++;
            @(negedge clk);
        end
    endtask

    task automatic post_run(input string name, input int n_edges);
        check($sformatf("%s latency", name), n_edges, LATENCY);
        check($sformatf("%s crd_cwr_overlap", name), overlap, 0);
        for (int i = 0; i < NPIX; i++)
            check($sformatf("%s L0[%0d]", name, i), mem0[i], exp0[i]);
        for (int i = 0; i < NPOOL; i++)
            check($sformatf("%s L1[%0d]", name, i), mem1[i], exp1[i]);
        repeat (3) @(negedge clk);
        check($sformatf("%s idle_after", name), {busy, cwr, crd}, 0);
    endtask

    initial begin
        fill_img(1'b0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, crd, cwr, csel, iaddr, caddr_rd, caddr_wr, cdata_wr}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        fill_img(1'b0);
        clear_exp();
        run_engine(1'b0, 1'b0, edges);
        post_run("zero", edges);

        fill_img(1'b0);
        img[10 * N + 10] = 13'h010;
        clear_exp();
        exp0[10 * N + 10] = 13'h004;
        exp1[5 * (N / 2) + 5] = 13'h010;
        run_engine(1'b0, 1'b0, edges);
        post_run("impulse_max", edges);

        run_engine(1'b1, 1'b0, edges);
        post_run("impulse_avg", edges);

        fill_img(1'b0);
        img[0] = 13'h080;
        clear_exp();
        exp0[0] = 13'h03C;
        exp1[0] = 13'h040;
        run_engine(1'b0, 1'b0, edges);
        post_run("corner", edges);

        fill_img(1'b1);
        compute_golden(1'b0);
        run_engine(1'b0, 1'b1, edges);
        post_run("rand_max", edges);

        compute_golden(1'b1);
        run_engine(1'b1, 1'b1, edges);
        post_run("rand_avg", edges);

        @(negedge clk); ready = 1'b1; pool_avg = 1'b0;
        @(negedge clk); ready = 1'b0;
        repeat (150) @(negedge clk);
        check("busy_before_abort", busy, 1);
        #1 reset = 1'b1;
        #1 check("abort_outputs", {busy, crd, cwr, csel, iaddr, caddr_rd, caddr_wr, cdata_wr}, 0);
        @(negedge clk);
        check("abort_outputs_held", {busy, crd, cwr, csel, iaddr, caddr_wr, cdata_wr}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("no_restart", busy, 0);

        fill_img(1'b1);
        compute_golden(1'b0);
        run_engine(1'b0, 1'b0, edges);
        post_run("rerun_max", edges);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
